prbs_checker: RTL and testbench
===============================

PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 SHALL have ports, clock and reset first: clk input 1, rising-edge clock; reset input 1, asynchronous, active-high.
REQ-002 SHALL have bit_valid input 1, qualifies bit_in in the current cycle.
REQ-003 SHALL have bit_in input 1, received serial bit from the 64-bit LFSR transmitter.
REQ-004 SHALL have clear_count input 1, synchronous clear of err_count.
REQ-005 SHALL have locked output 1, high while in the LOCKED state.
REQ-006 SHALL have state output 2, current FSM state encoding.
REQ-007 SHALL have err_pulse output 1, one-cycle strobe per bit error detected while LOCKED.
REQ-008 SHALL have err_count output 32, saturating count of LOCKED-state bit errors.

Function
REQ-009 SHALL hold a 64-bit history register r; bit 0 is the newest bit, and each shift moves r left and inserts the new bit at bit 0.
REQ-010 SHALL compute the predicted bit as r[63]^r[61]^r[59]^r[58], matching the transmitter feedback polynomial.
REQ-011 SHALL act only on cycles with bit_valid=1; with bit_valid=0, r, counters, state and err_count hold, and err_pulse=0.
REQ-012 SHALL have FSM states HUNT=0, VERIFY=1 and LOCKED=2; encoding 3 is unused and recovers to HUNT.
REQ-013 In HUNT, SHALL shift bit_in into r and increment fill count; the 64th valid bit moves the FSM to VERIFY.
REQ-014 In VERIFY, SHALL shift bit_in into r; on a match with the prediction it SHALL increment run count, and on a mismatch it SHALL clear run count to 0 and stay in VERIFY.
REQ-015 In VERIFY, a match SHALL NOT count while r==0, to reject LFSR lock-up; run count SHALL be cleared instead.
REQ-016 In VERIFY, when run count reaches LOCK_RUN=64, SHALL move to LOCKED.
REQ-017 In LOCKED, SHALL shift the predicted bit into r (flywheel), so received errors never corrupt r.
REQ-018 In LOCKED, a mismatch SHALL raise err_pulse for exactly the next cycle, increment err_count (saturating at 32'hFFFF_FFFF) and increment window error count.
REQ-019 In LOCKED, SHALL count valid bits in a window of LOSS_WINDOW=256; after the 256th bit, window bit count and window error count both clear to 0.
REQ-020 When window error count reaches LOSS_ERRS=8, including on the window's final bit, SHALL move to HUNT with fill count and run count cleared; err_count is retained.
REQ-021 All outputs SHALL be registered and update on the edge that samples bit_valid, so they are visible the following cycle.
REQ-022 clear_count SHALL take priority over increment: clear and an error on the same edge yields err_count=1, and clear alone yields 0.
REQ-023 Internal counters SHALL be sized so none wraps before its threshold is reached.

Reset
REQ-024 reset SHALL asynchronously force state=HUNT, r=0, all internal counters=0, locked=0, err_pulse=0 and err_count=0, including when asserted mid-LOCKED.
REQ-025 After reset deasserts, the first valid bit SHALL be treated as fill bit 1.

Structure
REQ-026 Package prbs_pkg SHALL hold the state enum, WIDTH=64, the tap constants 63/61/59/58, LOCK_RUN, LOSS_WINDOW and LOSS_ERRS.
REQ-027 prbs_pkg SHALL also hold a function computing the feedback bit from a 64-bit vector, shared with the transmitter.
REQ-028 The block SHALL be a single module with no sub-module; the FSM and datapath are in one always_ff plus combinational next-state logic.

Verification
REQ-029 LFSR seeded 64'h1, bit_valid continuous -> state=VERIFY after valid bit 64, and locked=1 in the cycle after valid bit 128.
REQ-030 Locked, flip one bit -> err_pulse high for exactly 1 cycle, err_count=1, locked stays 1.
REQ-031 Locked, 8 flipped bits within 256 valid bits -> locked=0 and state=HUNT after the 8th error; a clean stream re-locks 128 valid bits later; 7 errors per window never drop lock.
REQ-032 All-zero input for 1000 bits -> locked stays 0 and state stays HUNT/VERIFY with run count 0.
REQ-033 bit_valid at 50% random duty with a clean stream -> lock after 128 valid bits, with no state or output change on invalid cycles.
REQ-034 Reset mid-LOCKED with err_count=5 -> all outputs 0 immediately; clear_count and an error on the same edge -> err_count=1.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared PRBS-64 definitions: FSM states, polynomial taps, lock/loss thresholds
// and the feedback function used by both transmitter and checker.
package prbs_pkg;

    localparam int WIDTH       = 64;
    localparam int TAP_A       = 63;
    localparam int TAP_B       = 61;
    localparam int TAP_C       = 59;
    localparam int TAP_D       = 58;
    localparam int LOCK_RUN    = 64;
    localparam int LOSS_WINDOW = 256;
    localparam int LOSS_ERRS   = 8;

    localparam int CNT_W = $clog2(LOCK_RUN + 1);
    localparam int WIN_W = $clog2(LOSS_WINDOW);
    localparam int ERR_W = $clog2(LOSS_ERRS + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic prbs_feedback(input logic [WIDTH-1:0] v);
        return v[TAP_A] ^ v[TAP_B] ^ v[TAP_C] ^ v[TAP_D];
    endfunction

endpackage

// File: rtl/prbs_checker.sv
// PRBS-64 receive checker: hunt/verify/locked sync FSM with flywheel prediction and error counting.
// All outputs registered, visible one cycle after the sampling edge; idle (bit_valid=0) cycles hold all state.
module prbs_checker
    import prbs_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        bit_valid,
    input  logic        bit_in,
    input  logic        clear_count,
    output logic        locked,
    output logic [1:0]  state,
    output logic        err_pulse,
    output logic [31:0] err_count
);

    state_t             st_q, st_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic [CNT_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]   run_q, run_d;
    logic [WIN_W-1:0]   wbits_q, wbits_d;
    logic [ERR_W-1:0]   werr_q, werr_d, werr_next;
    logic [31:0]        errc_d;
    logic               pulse_d;
    logic               pred;
    logic               mismatch;

    assign state = st_q;

    always_comb begin
        pred      = prbs_feedback(r_q);
        mismatch  = bit_in ^ pred;
        werr_next = werr_q + {{(ERR_W-1){1'b0}}, mismatch};
        st_d      = st_q;
        r_d       = r_q;
        fill_d    = fill_q;
        run_d     = run_q;
        wbits_d   = wbits_q;
        werr_d    = werr_q;
        errc_d    = err_count;
        pulse_d   = 1'b0;

        if (bit_valid) begin
            // Clear first so a same-edge error still increments from zero.
            if (clear_count) begin
                errc_d = '0;
            end

            case (st_q)
                HUNT: begin
                    r_d = {r_q[WIDTH-2:0], bit_in};
                    if (fill_q == CNT_W'(WIDTH - 1)) begin
                        st_d   = VERIFY;
                        fill_d = '0;
                        run_d  = '0;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end

                VERIFY: begin
                    r_d = {r_q[WIDTH-2:0], bit_in};
                    // An all-zero history predicts zeros forever; never trust it.
                    if (!mismatch && (r_q != '0)) begin
                        if (run_q == CNT_W'(LOCK_RUN - 1)) begin
                            st_d    = LOCKED;
                            run_d   = '0;
                            wbits_d = '0;
                            werr_d  = '0;
                        end else begin
                            run_d = run_q + 1'b1;
                        end
                    end else begin
                        run_d = '0;
                    end
                end

                LOCKED: begin
                    r_d     = {r_q[WIDTH-2:0], pred};
                    pulse_d = mismatch;
                    if (mismatch && (errc_d != 32'hFFFF_FFFF)) begin
                        errc_d = errc_d + 32'd1;
                    end
                    if (werr_next == ERR_W'(LOSS_ERRS)) begin
                        st_d    = HUNT;
                        fill_d  = '0;
                        run_d   = '0;
                        wbits_d = '0;
                        werr_d  = '0;
                    end else if (wbits_q == WIN_W'(LOSS_WINDOW - 1)) begin
                        wbits_d = '0;
                        werr_d  = '0;
                    end else begin
                        wbits_d = wbits_q + 1'b1;
                        werr_d  = werr_next;
                    end
                end

                default: begin
                    st_d    = HUNT;
                    fill_d  = '0;
                    run_d   = '0;
                    wbits_d = '0;
                    werr_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q      <= HUNT;
            r_q       <= '0;
            fill_q    <= '0;
            run_q     <= '0;
            wbits_q   <= '0;
            werr_q    <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            st_q      <= st_d;
            r_q       <= r_d;
            fill_q    <= fill_d;
            run_q     <= run_d;
            wbits_q   <= wbits_d;
            werr_q    <= werr_d;
            locked    <= (st_d == LOCKED);
            err_pulse <= pulse_d;
            err_count <= errc_d;
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: a bit-history model predicts every output each cycle,
// and literal checks pin lock timing, error counting, loss of lock and reset behaviour.
module tb_prbs_checker;
    import prbs_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        bit_valid = 1'b0;
    logic        bit_in = 1'b0;
    logic        clear_count = 1'b0;
    logic        locked;
    logic [1:0]  state;
    logic        err_pulse;
    logic [31:0] err_count;

    int tests = 0;
    int fails = 0;

    logic [63:0] tx;

    // Reference model: last 64 bits as a plain array, mode/counters as integers.
    bit          hist [64];
    int          m_mode, fill, run, lbits, lerrs;
    logic        exp_locked, exp_pulse;
    logic [1:0]  exp_state;
    logic [31:0] exp_cnt;

    prbs_checker dut (
        .clk         (clk),
        .reset       (reset),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .clear_count (clear_count),
        .locked      (locked),
        .state       (state),
        .err_pulse   (err_pulse),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        foreach (hist[k]) hist[k] = 1'b0;
        m_mode = 0; fill = 0; run = 0; lbits = 0; lerrs = 0;
        exp_locked = 1'b0; exp_pulse = 1'b0; exp_state = 2'd0; exp_cnt = 32'd0;
    endtask

    task automatic model_update();
        bit pred, nz, nb;
        exp_pulse = 1'b0;
        if (bit_valid) begin
            pred = hist[63] ^ hist[61] ^ hist[59] ^ hist[58];
            nz = 1'b0;
            foreach (hist[k]) if (hist[k]) nz = 1'b1;
            if (clear_count) exp_cnt = 32'd0;
            nb = bit_in;
            if (m_mode == 0) begin
                fill++;
                if (fill == 64) begin m_mode = 1; run = 0; end
            end else if (m_mode == 1) begin
                if (bit_in == pred && nz) run++; else run = 0;
                if (run == 64) begin m_mode = 2; lbits = 0; lerrs = 0; end
            end else begin
                nb = pred;
                exp_pulse = (bit_in != pred);
                if (exp_pulse) begin
                    if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
                    lerrs++;
                end
                lbits++;
                if (lerrs == 8) begin
                    m_mode = 0; fill = 0; run = 0;
                end else if (lbits == 256) begin
                    lbits = 0; lerrs = 0;
                end
            end
            for (int k = 63; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = nb;
        end
        exp_state  = 2'(m_mode);
        exp_locked = (m_mode == 2);
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            tests++;
            if ({locked, state, err_pulse, err_count} !== {exp_locked, exp_state, exp_pulse, exp_cnt}) begin
                fails++;
                $display("FAIL model t=%0t: got locked=%0b state=%0d pulse=%0b cnt=%0d, want locked=%0b state=%0d pulse=%0b cnt=%0d",
                         $time, locked, state, err_pulse, err_count, exp_locked, exp_state, exp_pulse, exp_cnt);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Drives one cycle; returns 1 time unit after the sampling edge with inputs idled.
    task automatic step(input logic v, input logic b, input logic clr);
        bit_valid = v; bit_in = b; clear_count = clr;
        @(posedge clk);
        model_update();
        #1;
        bit_valid = 1'b0; clear_count = 1'b0;
    endtask

    task automatic tx_bit(input logic flip, input logic clr);
        logic b;
        b  = prbs_feedback(tx);
        tx = {tx[62:0], b};
        step(1'b1, b ^ flip, clr);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nvalid;
        model_reset();
        #2;
        reset = 1'b1;
        #1;
        check("reset_locked", 32'(locked), 0);
        check("reset_state", 32'(state), 0);
        check("reset_pulse", 32'(err_pulse), 0);
        check("reset_count", err_count, 0);
        do_reset();

        // Acquisition from seed 1 with continuous valid.
        tx = 64'h1;
        repeat (63) tx_bit(1'b0, 1'b0);
        check("hunt_after_63", 32'(state), 0);
        tx_bit(1'b0, 1'b0);
        check("verify_after_64", 32'(state), 1);
        repeat (63) tx_bit(1'b0, 1'b0);
        check("unlocked_after_127", 32'(locked), 0);
        tx_bit(1'b0, 1'b0);
        check("locked_after_128", 32'(locked), 1);
        check("state_locked", 32'(state), 2);

        // Single error while locked.
        tx_bit(1'b1, 1'b0);
        check("single_err_pulse", 32'(err_pulse), 1);
        check("single_err_count", err_count, 1);
        check("single_err_locked", 32'(locked), 1);
        tx_bit(1'b0, 1'b0);
        check("pulse_one_cycle", 32'(err_pulse), 0);

        // Eight errors in one window drop lock.
        repeat (6) tx_bit(1'b1, 1'b0);
        check("seven_errs_locked", 32'(locked), 1);
        tx_bit(1'b1, 1'b0);
        check("eighth_err_unlock", 32'(locked), 0);
        check("eighth_err_hunt", 32'(state), 0);
        check("eighth_err_count", err_count, 8);

        // Clean stream relocks 128 valid bits later.
        repeat (127) tx_bit(1'b0, 1'b0);
        check("relock_not_yet", 32'(locked), 0);
        tx_bit(1'b0, 1'b0);
        check("relock_128", 32'(locked), 1);
        check("count_retained", err_count, 8);

        // Seven errors per window for two windows keeps lock.
        for (int i = 0; i < 512; i++) begin
            int p;
            p = i % 256;
            tx_bit(((p == 3) || (p == 40) || (p == 80) || (p == 120) ||
                    (p == 160) || (p == 200) || (p == 250)) ? 1'b1 : 1'b0, 1'b0);
        end
        check("seven_per_window_locked", 32'(locked), 1);
        check("seven_per_window_count", err_count, 22);

        // Eighth error lands on the window's final bit.
        repeat (248) tx_bit(1'b0, 1'b0);
        repeat (7) tx_bit(1'b1, 1'b0);
        check("edge_window_still_locked", 32'(locked), 1);
        tx_bit(1'b1, 1'b0);
        check("edge_window_unlock", 32'(state), 0);
        check("edge_window_count", err_count, 30);

        // All-zero input never locks.
        do_reset();
        repeat (1000) step(1'b1, 1'b0, 1'b0);
        check("zeros_state_verify", 32'(state), 1);
        check("zeros_unlocked", 32'(locked), 0);

        // Randomly gapped valid with a clean stream.
        do_reset();
        tx = 64'h1;
        nvalid = 0;
        while (nvalid < 128) begin
            if ($urandom_range(0, 1) == 1) begin
                tx_bit(1'b0, 1'b0);
                nvalid++;
                if (nvalid == 127) check("gapped_not_locked", 32'(locked), 0);
                if (nvalid == 128) check("gapped_locked", 32'(locked), 1);
            end else begin
                step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end
        tx_bit(1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("idle_pulse_low", 32'(err_pulse), 0);
        check("idle_count_hold", err_count, 1);

        // Reset mid-LOCKED with five errors counted.
        repeat (4) begin
            tx_bit(1'b0, 1'b0);
            tx_bit(1'b1, 1'b0);
        end
        check("five_errs", err_count, 5);
        reset = 1'b1;
        #1;
        check("midlock_reset_locked", 32'(locked), 0);
        check("midlock_reset_state", 32'(state), 0);
        check("midlock_reset_count", err_count, 0);
        check("midlock_reset_pulse", 32'(err_pulse), 0);
        do_reset();

        // Clear priority over increment.
        repeat (128) tx_bit(1'b0, 1'b0);
        check("post_reset_relock", 32'(locked), 1);
        tx_bit(1'b1, 1'b0);
        tx_bit(1'b1, 1'b0);
        check("two_errs", err_count, 2);
        tx_bit(1'b1, 1'b1);
        check("clear_and_err", err_count, 1);
        tx_bit(1'b0, 1'b1);
        check("clear_alone", err_count, 0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
